// File: rtl/nios_system_pio_in_irq.sv
// Edge-capturing input PIO with Avalon-MM slave and level IRQ.
// Define PIO_DEBOUNCE_EN to build a per-channel debounce counter between the synchronizer and "stable".
`timescale 1ns/1ps
module nios_system_pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic [15:0] db_cnt [WIDTH];

  // A channel only moves once sync2 has disagreed with stable for DEBOUNCE_CYCLES cycles running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  assign stable = sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= '0;
    else          stable_d <= stable;
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = stable & ~stable_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~stable & stable_d;
    end else begin : g_any
      assign edge_det = stable ^ stable_d;
    end
  endgenerate

  assign wr_en    = chipselect && !write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge is OR-ed in after the clear so it survives a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irqmask      <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr_mask) | edge_det;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd2:    readdata <= 32'(irqmask);
        2'd3:    readdata <= 32'(edge_capture);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irqmask);

  logic unused_ok;
  assign unused_ok = &{1'b0, writedata, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Directed bench: three instances (rising, falling, any edge) share one bus and one input vector.
`timescale 1ns/1ps
module tb_nios_system_pio_in_irq;

`ifdef PIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'h0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));
  nios_system_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));
  nios_system_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  task automatic test_reset;
    #2;
    if (rd0 !== 32'h0) $display("FAIL reset_rd0 got %h exp 0", rd0); else passes++;
    checks++;
    if (rd2 !== 32'h0) $display("FAIL reset_rd2 got %h exp 0", rd2); else passes++;
    checks++;
    if ({irq0, irq1, irq2} !== 3'b000) $display("FAIL reset_irq got %b exp 000", {irq0, irq1, irq2}); else passes++;
    checks++;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    rd(2'd2);
    if (rd0 !== 32'h0) $display("FAIL reset_mask got %h exp 0", rd0); else passes++;
    checks++;
  endtask

  task automatic test_regs;
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    if (rd0 !== 32'hF) $display("FAIL mask_load got %h exp f", rd0); else passes++;
    checks++;
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0);
    address = 2'd2; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
    tick(1);
    write_n = 1'b1;
    rd(2'd2);
    if (rd0 !== 32'hF) $display("FAIL mask_ignored got %h exp f", rd0); else passes++;
    checks++;
    rd(2'd1);
    if (rd0 !== 32'h0) $display("FAIL addr1_zero got %h exp 0", rd0); else passes++;
    checks++;
  endtask

  task automatic test_rising;
    in_port = 4'b0101;
    tick(LAT - 1);
    if (irq0 !== 1'b0) $display("FAIL rise_early got %b exp 0", irq0); else passes++;
    checks++;
    tick(1);
    if (irq0 !== 1'b1) $display("FAIL rise_latency got %b exp 1", irq0); else passes++;
    checks++;
    if (irq1 !== 1'b0) $display("FAIL rise_fall_inst got %b exp 0", irq1); else passes++;
    checks++;
    rd(2'd3);
    if (rd0 !== 32'h5) $display("FAIL rise_cap got %h exp 5", rd0); else passes++;
    checks++;
    if (rd2 !== 32'h5) $display("FAIL rise_any_cap got %h exp 5", rd2); else passes++;
    checks++;
    rd(2'd0);
    if (rd0 !== 32'h5) $display("FAIL rise_stable got %h exp 5", rd0); else passes++;
    checks++;
    wr(2'd3, 32'hF);
    if ({irq0, irq2} !== 2'b00) $display("FAIL rise_clear got %b exp 00", {irq0, irq2}); else passes++;
    checks++;
  endtask

  task automatic test_clear_partial;
    in_port = 4'b0100;
    tick(LAT + 2);
    wr(2'd3, 32'hF);
    in_port = 4'b0111;
    tick(LAT + 1);
    wr(2'd2, 32'h2);
    if (irq0 !== 1'b1) $display("FAIL part_irq_set got %b exp 1", irq0); else passes++;
    checks++;
    wr(2'd3, 32'h2);
    if (irq0 !== 1'b0) $display("FAIL part_irq_clr got %b exp 0", irq0); else passes++;
    checks++;
    rd(2'd3);
    if (rd0 !== 32'h1) $display("FAIL part_cap got %h exp 1", rd0); else passes++;
    checks++;
  endtask

  task automatic test_edge_wins;
    wr(2'd3, 32'hF);
    in_port = 4'b0011;
    tick(LAT - 1);
    wr(2'd3, 32'h4);
    rd(2'd3);
    if (rd1 !== 32'h4) $display("FAIL win_fall got %h exp 4", rd1); else passes++;
    checks++;
    if (rd2 !== 32'h4) $display("FAIL win_any got %h exp 4", rd2); else passes++;
    checks++;
    if (rd0 !== 32'h0) $display("FAIL win_rise got %h exp 0", rd0); else passes++;
    checks++;
    wr(2'd3, 32'h4);
    rd(2'd3);
    if (rd1 !== 32'h0) $display("FAIL win_reclear got %h exp 0", rd1); else passes++;
    checks++;
  endtask

  task automatic test_any;
    wr(2'd3, 32'hF);
    in_port = 4'b1011;
    tick(LAT);
    rd(2'd3);
    if (rd2 !== 32'h8) $display("FAIL any_up got %h exp 8", rd2); else passes++;
    checks++;
    if (rd0 !== 32'h8) $display("FAIL any_up_rise got %h exp 8", rd0); else passes++;
    checks++;
    if (rd1 !== 32'h0) $display("FAIL any_up_fall got %h exp 0", rd1); else passes++;
    checks++;
    wr(2'd3, 32'h8);
    rd(2'd3);
    if (rd2 !== 32'h0) $display("FAIL any_clr got %h exp 0", rd2); else passes++;
    checks++;
    in_port = 4'b0011;
    tick(LAT);
    rd(2'd3);
    if (rd2 !== 32'h8) $display("FAIL any_down got %h exp 8", rd2); else passes++;
    checks++;
    if (rd1 !== 32'h8) $display("FAIL any_down_fall got %h exp 8", rd1); else passes++;
    checks++;
  endtask

  task automatic test_debounce;
    wr(2'd3, 32'hF);
    in_port = 4'b0010;
    tick(LAT + 2);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h1);
`ifdef PIO_DEBOUNCE_EN
    in_port = 4'b0011;
    tick(10);
    in_port = 4'b0010;
    tick(30);
    rd(2'd0);
    if (rd0 !== 32'h2) $display("FAIL glitch_stable got %h exp 2", rd0); else passes++;
    checks++;
    rd(2'd3);
    if (rd0 !== 32'h0) $display("FAIL glitch_cap got %h exp 0", rd0); else passes++;
    checks++;
    if (irq0 !== 1'b0) $display("FAIL glitch_irq got %b exp 0", irq0); else passes++;
    checks++;
`endif
    in_port = 4'b0011;
    tick(LAT - 1);
    if (irq0 !== 1'b0) $display("FAIL hold_early got %b exp 0", irq0); else passes++;
    checks++;
    tick(1);
    if (irq0 !== 1'b1) $display("FAIL hold_latency got %b exp 1", irq0); else passes++;
    checks++;
    rd(2'd3);
  endtask

  task automatic test_reset_mid;
    in_port = 4'b0111;
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    if (irq0 !== 1'b0) $display("FAIL rstmid_irq got %b exp 0", irq0); else passes++;
    checks++;
    if (rd0 !== 32'h0) $display("FAIL rstmid_rd got %h exp 0", rd0); else passes++;
    checks++;
    tick(2);
    reset_n = 1'b1;
    address = 2'd3;
    tick(LAT);
    if (rd0 !== 32'h0) $display("FAIL rel_early got %h exp 0", rd0); else passes++;
    checks++;
    tick(1);
    if (rd0 !== 32'h7) $display("FAIL rel_rise got %h exp 7", rd0); else passes++;
    checks++;
    if (rd1 !== 32'h0) $display("FAIL rel_fall got %h exp 0", rd1); else passes++;
    checks++;
    rd(2'd2);
    if (rd0 !== 32'h0) $display("FAIL rel_mask got %h exp 0", rd0); else passes++;
    checks++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_rising();
    test_clear_partial();
    test_edge_wins();
    test_any();
    test_debounce();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
